// File: rtl/subtree_resp_collector.sv
// rtl/subtree_resp_collector.sv - round-robin fan-in of child response beats into one registered parent stream
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   child_valid  per-child beat valid
//   child_data   per-child payload, child i at [i*DATA_W +: DATA_W]
//   child_ready  per-child accept, one-hot or zero
//   par_valid    parent-side beat valid (output register FULL)
//   par_data     parent-side payload
//   par_id       index of the child that sourced par_data
//   par_ready    parent accepts the beat
//   beat_cnt     saturating count of beats accepted from children
//   busy         par_valid or any child_valid
module subtree_resp_collector #(
  parameter int N_CHILD = 10,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CHILD-1:0]        child_valid,
  input  logic [N_CHILD*DATA_W-1:0] child_data,
  output logic [N_CHILD-1:0]        child_ready,
  output logic                      par_valid,
  output logic [DATA_W-1:0]         par_data,
  output logic [ID_W-1:0]           par_id,
  input  logic                      par_ready,
  output logic [CNT_W-1:0]          beat_cnt,
  output logic                      busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     sel;
  logic                found;
  logic [N_CHILD-1:0]  grant;
  logic [DATA_W-1:0]   sel_data;
  logic                load_en;
  logic                xfer;

  // Round-robin pick: first valid child strictly above last_grant, otherwise
  // wrap and take the lowest valid child (which may be last_grant itself).
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    grant    = '0;
    sel_data = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (!found && child_valid[i] && (ID_W'(i) > last_grant)) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_CHILD; i++) begin
      if (!found && child_valid[i]) begin
        found = 1'b1;
        sel   = ID_W'(i);
      end
    end
    for (int i = 0; i < N_CHILD; i++) begin
      if (found && (sel == ID_W'(i))) begin
        grant[i] = 1'b1;
        sel_data = child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A draining register may reload in the same cycle. rst_n gates the
  // transfer so child_ready is low for the whole time reset is held.
  assign load_en = (state_q == EMPTY) || par_ready;
  assign xfer    = rst_n && load_en && found;

  // Output-stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output-stage next state
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = FULL;
    end else if ((state_q == FULL) && par_ready) begin
      state_d = EMPTY;
    end
  end

  // Output-stage outputs
  always_comb begin
    par_valid   = (state_q == FULL);
    child_ready = xfer ? grant : '0;
    busy        = (state_q == FULL) || (|child_valid);
  end

  // Payload, tag, RR pointer and counter move only on a child-side transfer;
  // a drain without reload leaves par_data/par_id at their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_data   <= '0;
      par_id     <= '0;
      last_grant <= ID_W'(N_CHILD - 1);
      beat_cnt   <= '0;
    end else if (xfer) begin
      par_data   <= sel_data;
      par_id     <= sel;
      last_grant <= sel;
      if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/subtree_resp_collector.md
Name: subtree_resp_collector

Overview:
- Fan-in counterpart to the root-level fan-out tree: gathers response beats from N_CHILD child instances back into one parent-facing stream.
- Round-robin arbitration across children, with a single registered output stage and a valid/ready handshake on both sides.
- Each beat is tagged with the index of the child that sent it.
- Sits directly below a parent module, one per fan-out level.

Parameters:
- N_CHILD, 10, number of child response ports (2..16).
- DATA_W, 32, width of each response payload.
- ID_W, 4, width of the child index tag; must be >= ceil(log2(N_CHILD)).
- CNT_W, 16, width of the saturating accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- child_valid  input  N_CHILD  per-child response valid.
- child_data  input  N_CHILD*DATA_W  per-child payload, packed; child i occupies bits [i*DATA_W +: DATA_W].
- child_ready  output  N_CHILD  per-child accept; one-hot or zero.
- par_valid  output  1  parent-side beat valid.
- par_data  output  DATA_W  parent-side payload.
- par_id  output  ID_W  index of the child that sourced par_data.
- par_ready  input  1  parent accepts the beat.
- beat_cnt  output  CNT_W  total beats accepted from children; saturates at all-ones.
- busy  output  1  high whenever par_valid=1 or any child_valid=1.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream):
  - par_valid=0, par_data=0, par_id=0, beat_cnt=0, child_ready=0.
  - RR pointer last_grant=N_CHILD-1, so child 0 has first priority.
- Output stage (OUT_REG) is a one-entry register with two states:
  - EMPTY: par_valid=0.
  - FULL: par_valid=1.
- Load enable: load_en = !par_valid || par_ready.
  - A FULL register that drains this cycle may reload in the same cycle (back-to-back throughput, 1 beat/cycle).
- Arbitration (combinational, each cycle):
  - When load_en=1, scan children starting at (last_grant+1) mod N_CHILD, wrapping, and select the first with child_valid=1.
  - Assert child_ready for only that child.
  - When load_en=0 or no child is valid, child_ready=0.
- Transfer (on the clock edge when a child has child_valid & child_ready):
  - par_data <= child_data[sel]; par_id <= sel; par_valid <= 1.
  - last_grant <= sel.
  - beat_cnt <= beat_cnt+1 unless beat_cnt is all-ones.
- Drain only: if par_valid & par_ready and no child is granted, par_valid <= 0; par_data and par_id hold their last value.
- Stall: par_valid=1 and par_ready=0 → par_valid, par_data and par_id are held stable; child_ready=0.
- Latency: a child beat accepted in cycle N appears on par_* in cycle N+1.
- Fairness:
  - A continuously-valid child waits at most N_CHILD-1 grants between its own grants.
  - last_grant updates only on an actual transfer.
- Child protocol: children must hold child_valid and child_data until they see ready. The collector never drops or duplicates a beat.
- Wrap-around: the RR scan wraps from index N_CHILD-1 to 0. ID_W bits above the child index read as 0.
- Simultaneous drain and load: the register is overwritten with the new beat; par_valid stays 1.
- Reset mid-operation:
  - An in-flight par_* beat is discarded.
  - child_ready drops to 0 immediately (combinational from reset state).
  - The RR pointer returns to N_CHILD-1.
- beat_cnt: counts child-side transfers, not parent-side ones. It holds at saturation until reset.
- busy: combinational OR of par_valid and all child_valid bits.

Test Plan:
- Reset with child_valid=all-ones → child_ready=0, par_valid=0, beat_cnt=0 while rst_n=0; the first grant after release goes to child 0.
- All 10 children valid, par_ready=1 constantly, child i data=0x100+i → par_id sequence 0,1,...,9,0 on consecutive cycles; data matches; beat_cnt=10 after 10 cycles.
- Only child 7 valid with data 0xDEADBEEF, par_ready=0 for 5 cycles → par_valid=1 with 0xDEADBEEF/id 7 held stable; child_ready[7]=0 after the first transfer; beat_cnt=1.
- Children 3 and 8 valid, last grant was 3 → next grant goes to 8, then 3; alternation continues; neither starves.
- Assert rst_n=0 while par_valid=1 mid-stream → par_valid=0 asynchronously; after release, child 0 is granted first and no beat is duplicated.
- CNT_W=4, force 20 transfers → beat_cnt stops at 15.
